// File: rtl/hdmi_video_tx.sv
// HDMI video transmitter: parametrised raster timing generator, live pixel FIFO
// aligned to the raster by a start-of-frame marker, and colour-bar / solid-fill patterns.
module hdmi_video_tx #(
  parameter int DW         = 8,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [1:0]      mode,
  input  logic [3*DW-1:0] fill_color,
  input  logic [3*DW-1:0] in_data,
  input  logic            in_sof,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [3*DW-1:0] out_data,
  output logic            out_de,
  output logic            out_hsync,
  output logic            out_vsync,
  output logic            frame_start,
  output logic            underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int PW      = 3 * DW;
  localparam int BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {
    MODE_LIVE = 2'd0,
    MODE_BARS = 2'd1,
    MODE_FILL = 2'd2
  } mode_t;

  typedef enum logic {
    ST_ALIGN = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Raster counters
  logic [HW-1:0] h;
  logic [VW-1:0] v;

  // NOTE: sequential state is assigned with <= so every register in the design
  // updates from the values seen before the clock edge, independent of block order.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      h <= '0;
      v <= '0;
    end else if (h == HW'(H_TOTAL - 1)) begin
      h <= '0;
      v <= (v == VW'(V_TOTAL - 1)) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  logic at_origin, de_c, hs_c, vs_c;

  assign at_origin = enable && (h == '0) && (v == '0);
  assign de_c      = enable && (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
  assign hs_c      = enable && (h >= HW'(H_ACTIVE + H_FP))
                            && (h <  HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_c      = enable && (v >= VW'(V_ACTIVE + V_FP))
                            && (v <  VW'(V_ACTIVE + V_FP + V_SYNC));

  // Frame-wide mode: the origin pixel already uses the freshly sampled values
  mode_t         mode_in, eff_mode, frame_mode;
  logic [PW-1:0] eff_fill, frame_fill;

  assign mode_in  = (mode == 2'd3) ? MODE_FILL : mode_t'(mode);
  assign eff_mode = at_origin ? mode_in : frame_mode;
  assign eff_fill = at_origin ? fill_color : frame_fill;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_mode <= MODE_LIVE;
      frame_fill <= '0;
    end else if (at_origin) begin
      frame_mode <= mode_in;
      frame_fill <= fill_color;
    end
  end

  // Pixel FIFO, first-word-fall-through, entries are {sof, data}
  logic [PW:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          rst_done, flush, full, empty, push, pop;
  logic          head_sof;
  logic [PW-1:0] head_data;

  assign flush    = (frame_mode != MODE_LIVE);
  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign in_ready = rst_done && (flush || !full);
  assign push     = in_valid && in_ready && !flush;
  assign {head_sof, head_data} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) rst_done <= 1'b0;
    else     rst_done <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; pointers and count alone decide
  // which entries are valid, so clearing them is enough.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_sof, in_data};
  end

  // Live-mode alignment FSM
  state_t        state, state_n;
  logic          live_c, uf_c;
  logic [PW-1:0] live_pix;

  assign live_c = enable && (eff_mode == MODE_LIVE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_ALIGN;
    else     state <= state_n;
  end

  // NOTE: every always_comb output gets a default first, so no branch can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_n = state;
    if (!live_c) begin
      state_n = ST_ALIGN;
    end else begin
      case (state)
        ST_ALIGN: if (!empty && head_sof && at_origin) state_n = ST_RUN;
        ST_RUN:   if (de_c && (empty || (head_sof && !at_origin))) state_n = ST_ALIGN;
        default:  state_n = ST_ALIGN;
      endcase
    end
  end

  always_comb begin
    pop      = 1'b0;
    uf_c     = 1'b0;
    live_pix = '0;
    if (live_c) begin
      case (state)
        ST_ALIGN: begin
          if (!empty && !head_sof) begin
            pop = 1'b1;
          end else if (!empty && head_sof && at_origin) begin
            pop      = 1'b1;
            live_pix = head_data;
          end
        end
        ST_RUN: begin
          if (de_c) begin
            if (empty || (head_sof && !at_origin)) begin
              uf_c = 1'b1;
            end else begin
              pop      = 1'b1;
              live_pix = head_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Colour bars: white, yellow, cyan, green, magenta, red, blue, black
  logic [2:0]    bar_idx;
  logic [PW-1:0] bar_rgb, pix;

  always_comb begin
    int idx;
    idx = int'(h) / BAR_W;
    if (idx > 7) idx = 7;
    bar_idx = 3'(idx);
  end

  assign bar_rgb = {{DW{~bar_idx[1]}}, {DW{~bar_idx[2]}}, {DW{~bar_idx[0]}}};

  always_comb begin
    case (eff_mode)
      MODE_LIVE: pix = live_pix;
      MODE_BARS: pix = bar_rgb;
      default:   pix = eff_fill;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data    <= '0;
      out_de      <= 1'b0;
      out_hsync   <= ~HS_POL;
      out_vsync   <= ~VS_POL;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      out_data    <= de_c ? pix : '0;
      out_de      <= de_c;
      out_hsync   <= hs_c ? HS_POL : ~HS_POL;
      out_vsync   <= vs_c ? VS_POL : ~VS_POL;
      frame_start <= at_origin;
      underflow   <= uf_c;
    end
  end

endmodule

// File: doc/hdmi_video_tx.md
# hdmi_video_tx

Parametrised HDMI video transmitter that generates the full raster timing (DE/HSYNC/VSYNC) for any mode set by parameters. It accepts a pixel stream through a valid/ready handshake into an internal FIFO and aligns that stream to the raster on a start-of-frame marker. It also offers colour-bar and solid-fill test modes, and sits between the pixel source and the HDMI transmitter pins alongside the IIC configuration and S/PDIF audio blocks. One pixel is emitted per `clk` cycle; `clk` is the pixel clock.

## Interface
- `DW`, 8, bits per colour channel
- `H_ACTIVE`, 640, active pixels per line
- `H_FP`, 16, horizontal front porch (cycles)
- `H_SYNC`, 96, horizontal sync width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, active lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width
- `V_BP`, 33, vertical back porch
- `HS_POL`, 0, asserted level of `out_hsync`
- `VS_POL`, 0, asserted level of `out_vsync`
- `FIFO_DEPTH`, 16, pixel FIFO entries (power of 2, ≥2)

Ports:
- `clk`  in  1  pixel clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `enable`  in  1  raster running when high
- `mode`  in  2  0 live, 1 colour bars, 2 solid fill, 3 treated as 2
- `fill_color`  in  3*DW  {R,G,B} for solid fill
- `in_data`  in  3*DW  {R,G,B} input pixel
- `in_sof`  in  1  marks the first pixel of a frame
- `in_valid`  in  1  input word valid
- `in_ready`  out  1  FIFO can accept
- `out_data`  out  3*DW  {R,G,B} to transmitter
- `out_de`, `out_hsync`, `out_vsync`  out  1 each  raster controls
- `frame_start`  out  1  one-cycle pulse coincident with the first DE of a frame
- `underflow`  out  1  one-cycle pulse on live-mode starvation or misalignment

## Operation
- Totals: H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters. Counters are `h` in 0..H_TOTAL-1 and `v` in 0..V_TOTAL-1. `h` wraps to 0 and increments `v`; `v` wraps to 0 after V_TOTAL-1.
- Line order: active, FP, sync, BP. Frame order is the same, in whole lines.
- DE when h<H_ACTIVE && v<V_ACTIVE.
- hsync asserted for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, on every line.
- vsync asserted for lines V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, for the whole line.
- Sync outputs drive the POL value when asserted and its inverse otherwise.
- `mode` and `fill_color` are sampled only at (h,v)=(0,0); the sampled values hold for the whole frame.
- Colour bars: bar index = h / (H_ACTIVE/8), clamped to 7. Bars in order are white, yellow, cyan, green, magenta, red, blue, black, where each channel is all-ones or 0.
- Blanking: `out_data` = 0 whenever DE is low.
- FIFO:
  - Entries are {sof, data}, first-word-fall-through.
  - `in_ready` = !full.
  - A write occurs on `in_valid && in_ready`.
  - A word written while the FIFO is empty is poppable the next cycle.
  - While the frame mode is non-live, the FIFO is flushed each cycle and `in_ready` = 1, so input is discarded.
- Live-mode FSM:
  - ALIGN (entered on reset/disable):
    - Pops and discards words whose sof is 0.
    - Holds a sof=1 head until (h,v)=(0,0), then goes to RUN.
    - Pixels output during ALIGN are black.
  - RUN:
    - On each DE cycle, pops the head word and outputs it.
    - If the FIFO is empty on a DE cycle: output black, pulse `underflow`, go to ALIGN.
    - If the head has sof=1 at any DE position other than (0,0): do not pop it, output black, pulse `underflow`, go to ALIGN.
    - A sof=1 head at (0,0) in RUN is popped normally.
- `enable`=0:
  - Counters are held at 0 and the FSM returns to ALIGN.
  - `out_de`=0, syncs are deasserted, `frame_start`=0.
  - The FIFO keeps accepting until full.
  - Counting resumes from (0,0) the cycle after `enable` rises.

## Timing
- Outputs are registered. Raster position (h,v) appears on all outputs one cycle after the counters hold it.
- `out_data` for a popped pixel is on the same output cycle as its DE.
- Reset values:
  - `out_data`=0, `out_de`=0, `out_hsync`=!HS_POL, `out_vsync`=!VS_POL.
  - `frame_start`=0, `underflow`=0, `in_ready`=0.
  - `in_ready` goes to 1 the first cycle after `rst` is released.
  - FIFO is empty, FSM is in ALIGN, counters are at (0,0).
- `rst` mid-line takes effect in the next cycle: the raster restarts at (0,0) and FIFO contents are lost.
- Frame period is H_TOTAL·V_TOTAL cycles. `frame_start` pulses once per frame, in every mode.

## Test plan
Use H=8/2/2/2 (H_TOTAL 14), V=4/1/1/1 (V_TOTAL 7), FIFO_DEPTH=4, mode=1 unless stated.

- Raster timing, enable=1: `out_de` high for 8 of every 14 cycles on 4 of 7 lines; `out_hsync`=0 on h=10..11; `out_vsync`=0 for all 14 cycles of line 5; `frame_start` pulses every 98 cycles.
- Colour bars: `out_data` over the 8 active pixels of each line = FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. Switch to mode=2, fill 123456, mid-frame → change appears only from the next `frame_start`.
- Live alignment: mode=0; push 3 sof=0 junk words, then a 32-pixel frame with values 1..32 and sof on word 1 → junk is discarded, the first DE after `frame_start` shows 1, then 2..32 in raster order, `underflow` never pulses.
- Underflow: stop `in_valid` after 20 pixels → `underflow` pulses exactly once, at active pixel 21; pixels 21..32 are 0; next sof-aligned frame displays correctly.
- Backpressure: enable=0, `in_valid` held high → exactly 4 words accepted, `in_ready`=0 thereafter; raising `enable` drains the FIFO and `in_ready` returns to 1.
- Reset mid-operation: assert `rst` for 1 cycle at h=5, v=2 → next cycle all outputs hold reset values, `in_ready`=0; the first `frame_start` follows 1 cycle after release.
